// File: rtl/cc_branch_unit.sv
// ---------------------------------------------------------------------------
// cc_branch_unit
//   Condition-code generation, a condition-code register, the branch-taken
//   decision, and retired/mispredicted branch counters.
//
// Ports
//   clk              in   rising-edge clock for all state
//   clr              in   asynchronous active-high reset
//   value_in         in   result value whose sign/zero status sets the codes
//   ld_cc            in   load enable for the condition-code register
//   nzp_in           in   branch condition mask (bit2 n, bit1 z, bit0 p)
//   br_valid         in   a branch is retiring this cycle
//   predict_in       in   predicted direction of the retiring branch (1 = taken)
//   gencc_out        out  combinational one-hot nzp code of value_in
//   cc_out           out  registered condition code
//   branch_enable    out  combinational branch-taken decision
//   mispredict       out  br_valid and decision differs from prediction
//   branch_count     out  retired-branch counter (wraps)
//   mispredict_count out  mispredicted-branch counter (wraps)
// ---------------------------------------------------------------------------
module cc_branch_unit #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] value_in,
  input  logic                  ld_cc,
  input  logic [2:0]            nzp_in,
  input  logic                  br_valid,
  input  logic                  predict_in,
  output logic [2:0]            gencc_out,
  output logic [2:0]            cc_out,
  output logic                  branch_enable,
  output logic                  mispredict,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  logic [2:0]  cc_q, cc_d;
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  // Sign bit is tested first, so the result is always exactly one-hot.
  always_comb begin
    gencc_out = 3'b001;
    if (value_in[DATA_WIDTH-1]) begin
      gencc_out = 3'b100;
    end else if (value_in == '0) begin
      gencc_out = 3'b010;
    end
  end

  // The decision is taken from the registered code, so a branch retiring on
  // the same edge as a cc load sees the value from before that load.
  always_comb begin
    branch_enable = |(cc_q & nzp_in);
    mispredict    = br_valid & (branch_enable != predict_in);
  end

  always_comb begin
    cc_d               = cc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (ld_cc) begin
      cc_d = gencc_out;
    end
    if (br_valid) begin
      branch_count_d = branch_count_q + 32'd1;
      if (mispredict) begin
        mispredict_count_d = mispredict_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cc_q               <= 3'b000;
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      cc_q               <= cc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign cc_out           = cc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_cc_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_cc_branch_unit
//   Self-checking bench for cc_branch_unit: a table of condition-code vectors,
//   hand-written multi-cycle sequences, and randomized traffic compared with
//   a behavioural model of the condition code and the two counters.
// ---------------------------------------------------------------------------
module tb_cc_branch_unit;

  logic        clk;
  logic        clr;
  logic [15:0] value_in;
  logic        ld_cc;
  logic [2:0]  nzp_in;
  logic        br_valid;
  logic        predict_in;
  logic [2:0]  gencc_out;
  logic [2:0]  cc_out;
  logic        branch_enable;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  cc_branch_unit #(.DATA_WIDTH(16)) dut (
    .clk              (clk),
    .clr              (clr),
    .value_in         (value_in),
    .ld_cc            (ld_cc),
    .nzp_in           (nzp_in),
    .br_valid         (br_valid),
    .predict_in       (predict_in),
    .gencc_out        (gencc_out),
    .cc_out           (cc_out),
    .branch_enable    (branch_enable),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [2:0]  m_cc;
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  typedef struct {
    logic [15:0] value;
    logic [2:0]  gencc;
  } gvec_t;

  gvec_t gtab[5];

  function automatic logic [2:0] ref_gencc(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic ref_taken(input logic [2:0] cc, input logic [2:0] nzp);
    // Taken when any condition selected by the mask is currently set.
    for (int k = 0; k < 3; k++) begin
      if (cc[k] && nzp[k]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Advance one clock; the model is updated from the inputs held before the edge.
  task automatic cycle();
    logic taken;
    taken = ref_taken(m_cc, nzp_in);
    if (br_valid) begin
      m_bc = m_bc + 32'd1;
      if (taken != predict_in) m_mc = m_mc + 32'd1;
    end
    if (ld_cc) m_cc = ref_gencc(value_in);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    #1 clr = 1'b1;
    #2 clr = 1'b0;
    m_cc = 3'b000;
    m_bc = 32'd0;
    m_mc = 32'd0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".cc_out"}, {29'd0, cc_out}, {29'd0, m_cc});
    chk({tag, ".branch_count"}, branch_count, m_bc);
    chk({tag, ".mispredict_count"}, mispredict_count, m_mc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    gtab[0] = '{16'h0000, 3'b010};
    gtab[1] = '{16'h0001, 3'b001};
    gtab[2] = '{16'h7FFF, 3'b001};
    gtab[3] = '{16'h8000, 3'b100};
    gtab[4] = '{16'hFFFF, 3'b100};

    clr = 1'b1; value_in = 16'h0; ld_cc = 1'b0; nzp_in = 3'b000;
    br_valid = 1'b0; predict_in = 1'b0;
    m_cc = 3'b000; m_bc = 32'd0; m_mc = 32'd0;

    // Reset state, held across clock edges
    @(negedge clk); @(negedge clk);
    chk_state("reset");
    for (int n = 0; n < 8; n++) begin
      nzp_in = 3'(n);
      #1 chk($sformatf("reset.branch_enable nzp=%0d", n), {31'd0, branch_enable}, 32'd0);
    end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Condition-code generation table
    for (int i = 0; i < 5; i++) begin
      value_in = gtab[i].value;
      #1 chk($sformatf("gencc %04h", gtab[i].value), {29'd0, gencc_out}, {29'd0, gtab[i].gencc});
    end
    @(negedge clk);

    // Load then hold
    value_in = 16'hFFFE; ld_cc = 1'b1;
    cycle();
    chk("load.cc_out", {29'd0, cc_out}, 32'h4);
    ld_cc = 1'b0; value_in = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("hold%0d.cc_out", i), {29'd0, cc_out}, 32'h4);
    end

    // Branch decision with cc = z
    value_in = 16'h0000; ld_cc = 1'b1;
    cycle();
    ld_cc = 1'b0;
    nzp_in = 3'b010; #1 chk("be z/010", {31'd0, branch_enable}, 32'd1);
    nzp_in = 3'b101; #1 chk("be z/101", {31'd0, branch_enable}, 32'd0);
    nzp_in = 3'b000; #1 chk("be z/000", {31'd0, branch_enable}, 32'd0);
    nzp_in = 3'b111; #1 chk("be z/111", {31'd0, branch_enable}, 32'd1);
    @(negedge clk);

    // Counters: four branches, alternating prediction
    pulse_reset();
    value_in = 16'h0005; ld_cc = 1'b1;
    cycle();
    ld_cc = 1'b0; nzp_in = 3'b001; br_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      predict_in = (i % 2 == 0);
      #1 chk($sformatf("cnt%0d.mispredict", i), {31'd0, mispredict}, (i % 2 == 0) ? 32'd0 : 32'd1);
      cycle();
    end
    br_valid = 1'b0;
    chk("cnt.branch_count", branch_count, 32'd4);
    chk("cnt.mispredict_count", mispredict_count, 32'd2);

    // Decision uses the pre-edge condition code
    nzp_in = 3'b001; predict_in = 1'b1; br_valid = 1'b1; ld_cc = 1'b1; value_in = 16'h0000;
    cycle();
    br_valid = 1'b0; ld_cc = 1'b0;
    chk("preedge.mispredict_count", mispredict_count, 32'd2);
    chk("preedge.cc_out", {29'd0, cc_out}, 32'h2);
    chk("preedge.branch_count", branch_count, 32'd5);

    // Mispredict suppressed when no branch retires
    nzp_in = 3'b111; predict_in = 1'b0; br_valid = 1'b0;
    #1 chk("nobranch.mispredict", {31'd0, mispredict}, 32'd0);
    cycle();
    chk_state("nobranch");

    // Reset mid-operation, between edges
    value_in = 16'h8001; ld_cc = 1'b1;
    cycle();
    ld_cc = 1'b0;
    chk("pre_clr.cc_out", {29'd0, cc_out}, 32'h4);
    #1 clr = 1'b1;
    #1;
    chk("clr.cc_out", {29'd0, cc_out}, 32'd0);
    chk("clr.branch_count", branch_count, 32'd0);
    chk("clr.mispredict_count", mispredict_count, 32'd0);
    clr = 1'b0;
    m_cc = 3'b000; m_bc = 32'd0; m_mc = 32'd0;
    // First edge after reset operates normally
    value_in = 16'h0003; ld_cc = 1'b1; br_valid = 1'b1; nzp_in = 3'b111; predict_in = 1'b0;
    cycle();
    ld_cc = 1'b0; br_valid = 1'b0;
    chk_state("post_clr");

    // Branch counter wrap
    force dut.branch_count_q = 32'hFFFFFFFF;
    #1 release dut.branch_count_q;
    m_bc = 32'hFFFFFFFF;
    #1 chk("wrap.preload", branch_count, 32'hFFFFFFFF);
    br_valid = 1'b1; predict_in = 1'b1; nzp_in = 3'b001;
    cycle();
    br_valid = 1'b0;
    chk("wrap.branch_count", branch_count, 32'd0);
    chk("wrap.mispredict_count", mispredict_count, m_mc);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(63) == 0) begin
        pulse_reset();
      end
      case ($urandom_range(3))
        0:       value_in = 16'h0000;
        1:       value_in = 16'(32'h8000 | $urandom_range(16'h7FFF));
        default: value_in = 16'($urandom);
      endcase
      ld_cc      = 1'($urandom);
      nzp_in     = 3'($urandom);
      br_valid   = 1'($urandom);
      predict_in = 1'($urandom);
      #1;
      chk($sformatf("rnd%0d.gencc", i), {29'd0, gencc_out}, {29'd0, ref_gencc(value_in)});
      chk($sformatf("rnd%0d.branch_enable", i), {31'd0, branch_enable},
          {31'd0, ref_taken(m_cc, nzp_in)});
      chk($sformatf("rnd%0d.mispredict", i), {31'd0, mispredict},
          {31'd0, br_valid && (ref_taken(m_cc, nzp_in) != predict_in)});
      cycle();
      chk_state($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
